// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv
// Pipelined WIDTH-input AND/NAND reduction built from AND4 nodes, one register
// stage per tree level, with valid tracking, global enable and per-bit mask.
module gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(
  parameter int WIDTH = 16,
  parameter bit INV   = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             IV,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] MASK,
  output logic             Z,
  output logic             ZV
);

  function automatic int pow4(input int k);
    int p;
    p = 32'sd1;
    for (int i = 0; i < k; i++) p = p * 32'sd4;
    return p;
  endfunction

  function automatic int nodes(input int w, input int k);
    return (w + pow4(k) - 32'sd1) / pow4(k);
  endfunction

  function automatic int depth(input int w);
    int n;
    int d;
    n = w;
    d = 32'sd0;
    for (int i = 0; i < 8; i++) begin
      if (n > 32'sd1) begin
        n = (n + 32'sd3) / 32'sd4;
        d = d + 32'sd1;
      end
    end
    return d;
  endfunction

  // Bit position of level k's first node inside the flattened stage register.
  function automatic int offset(input int w, input int k);
    int s;
    s = 32'sd0;
    for (int j = 1; j < k; j++) s = s + nodes(w, j);
    return s;
  endfunction

  localparam int L      = depth(WIDTH);
  localparam int TOT    = offset(WIDTH, L + 1);
  localparam int TREE_W = WIDTH + TOT - 1;

  if (WIDTH < 2 || WIDTH > 256) begin : g_bad_width
    $error("andn_pipe: WIDTH must be within 2..256");
  end

  logic [WIDTH-1:0]  e_s;
  logic [TREE_W-1:0] tree_s;
  logic [TOT-1:0]    node_s;
  logic [TOT-1:0]    ld_s;
  logic [TOT-1:0]    data_d;
  logic [TOT-1:0]    data_q;
  logic [L-1:0]      vin_s;
  logic [L-1:0]      valid_d;
  logic [L-1:0]      valid_q;

  assign e_s = A | MASK;

  // Level 0 is the masked input; every other level is read from its register.
  if (TOT > 1) begin : g_tree_deep
    assign tree_s = {data_q[TOT-2:0], e_s};
  end else begin : g_tree_flat
    assign tree_s = e_s;
  end

  if (L == 1) begin : g_vin_one
    assign vin_s = IV;
  end else begin : g_vin_chain
    assign vin_s = {valid_q[L-2:0], IV};
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int NI = nodes(WIDTH, k - 1);
    localparam int NO = nodes(WIDTH, k);
    localparam int IB = (k == 1) ? 0 : WIDTH + offset(WIDTH, k - 1);
    localparam int OB = offset(WIDTH, k);

    for (genvar j = 0; j < NO; j++) begin : g_node
      logic [3:0] leaf_s;

      // Inputs past the end of the previous level are padded with 1.
      for (genvar m = 0; m < 4; m++) begin : g_leaf
        if (4 * j + m < NI) begin : g_src
          assign leaf_s[m] = tree_s[IB + 4 * j + m];
        end else begin : g_pad
          assign leaf_s[m] = 1'b1;
        end
      end

      if (k == L) begin : g_root
        assign node_s[OB + j] = (&leaf_s) ^ INV;
      end else begin : g_inner
        assign node_s[OB + j] = &leaf_s;
      end

      assign ld_s[OB + j] = EN & vin_s[k-1];
    end
  end

  // Stage data loads only on a valid advance; valid bits shift whenever enabled.
  always_comb begin
    data_d  = (ld_s & node_s) | (~ld_s & data_q);
    valid_d = EN ? vin_s : valid_q;
  end

  // Pipeline state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= {TOT{1'b0}};
      valid_q <= {L{1'b0}};
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign Z  = data_q[TOT-1];
  assign ZV = valid_q[L-1];

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv
// Scoreboard bench for the pipelined AND/NAND reduction at WIDTH 16, 5 (NAND),
// 256 and 3, with directed latency, stall, bubble and reset checks.
module tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe;

  logic CLK = 1'b0;
  logic RST;
  logic EN;
  logic IV;
  logic [15:0]  a16, m16;
  logic [4:0]   a5, m5;
  logic [255:0] a256, m256;
  logic [2:0]   a3, m3;
  logic z16, zv16, z5, zv5, z256, zv256, z3, zv3;
  logic en_edge;

  int n_pass  = 0;
  int n_total = 0;
  bit q16[$];
  bit q5[$];
  bit q256[$];
  bit q3[$];

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(16), .INV(1'b0)) u_w16 (
    .CLK(CLK), .RST(RST), .EN(EN), .IV(IV), .A(a16), .MASK(m16), .Z(z16), .ZV(zv16));
  gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(5), .INV(1'b1)) u_w5 (
    .CLK(CLK), .RST(RST), .EN(EN), .IV(IV), .A(a5), .MASK(m5), .Z(z5), .ZV(zv5));
  gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(256), .INV(1'b0)) u_w256 (
    .CLK(CLK), .RST(RST), .EN(EN), .IV(IV), .A(a256), .MASK(m256), .Z(z256), .ZV(zv256));
  gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(3), .INV(1'b0)) u_w3 (
    .CLK(CLK), .RST(RST), .EN(EN), .IV(IV), .A(a3), .MASK(m3), .Z(z3), .ZV(zv3));

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic iv, input logic [15:0] a_16,
                       input logic [15:0] m_16, input logic [4:0] a_5,
                       input logic [255:0] a_256, input logic [2:0] a_3);
    EN = en; IV = iv; a16 = a_16; m16 = m_16; a5 = a_5; a256 = a_256; a3 = a_3;
    if (en && iv) begin
      q16.push_back(&(a_16 | m_16));
      q5.push_back(~(&a_5));
      q256.push_back(&a_256);
      q3.push_back(&a_3);
    end
  endtask

  always @(posedge CLK) en_edge <= EN;

  // Each result edge with ZV=1 retires exactly one scoreboard entry in order.
  always @(negedge CLK) begin
    if (!RST && en_edge) begin
      if (zv16) begin
        check("sb16_pending", (q16.size() > 0) ? 1'b1 : 1'b0, 1'b1);
        if (q16.size() > 0) check("sb16_z", z16, q16.pop_front());
      end
      if (zv5) begin
        check("sb5_pending", (q5.size() > 0) ? 1'b1 : 1'b0, 1'b1);
        if (q5.size() > 0) check("sb5_z", z5, q5.pop_front());
      end
      if (zv256) begin
        check("sb256_pending", (q256.size() > 0) ? 1'b1 : 1'b0, 1'b1);
        if (q256.size() > 0) check("sb256_z", z256, q256.pop_front());
      end
      if (zv3) begin
        check("sb3_pending", (q3.size() > 0) ? 1'b1 : 1'b0, 1'b1);
        if (q3.size() > 0) check("sb3_z", z3, q3.pop_front());
      end
    end
  end

  initial begin
    logic [255:0] ones;
    logic [255:0] no255;
    logic [15:0]  sa [4];
    logic         ez [4];

    ones = {256{1'b1}};
    no255 = ones;
    no255[255] = 1'b0;
    sa[0] = 16'hFFFF; sa[1] = 16'hFFFE; sa[2] = 16'h7FFF; sa[3] = 16'hFFFF;

    RST = 1'b1; EN = 1'b1; IV = 1'b0;
    a16 = 16'h0000; m16 = 16'h0000; a5 = 5'h00; m5 = 5'h00;
    a256 = {256{1'b0}}; m256 = {256{1'b0}}; a3 = 3'h0; m3 = 3'h0;
    #2;
    check("rst_z16", z16, 1'b0);   check("rst_zv16", zv16, 1'b0);
    check("rst_z5", z5, 1'b0);     check("rst_zv5", zv5, 1'b0);
    check("rst_z256", z256, 1'b0); check("rst_zv3", zv3, 1'b0);
    tick();
    tick();
    RST = 1'b0;

    // Single sample: latency 1/2/4 and hold of Z after ZV drops.
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0000, 5'h1F, ones, 3'h7);
    tick();
    check("t1_zv16_early", zv16, 1'b0);
    check("t1_zv3", zv3, 1'b1); check("t1_z3", z3, 1'b1);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 5'h00, {256{1'b0}}, 3'h0);
    tick();
    check("t1_zv16", zv16, 1'b1); check("t1_z16", z16, 1'b1);
    check("t1_zv5", zv5, 1'b1);   check("t1_z5", z5, 1'b0);
    check("t1_zv3_drop", zv3, 1'b0); check("t1_z3_hold", z3, 1'b1);
    tick();
    check("t1_zv16_drop", zv16, 1'b0); check("t1_z16_hold", z16, 1'b1);
    check("t1_zv256_early", zv256, 1'b0);
    tick();
    check("t1_zv256", zv256, 1'b1); check("t1_z256", z256, 1'b1);
    tick();
    check("t1_zv256_drop", zv256, 1'b0);

    // Back-to-back stream, second pass masks bit 0 of the second sample.
    for (int p = 0; p < 2; p++) begin
      ez[0] = 1'b1; ez[1] = (p == 1) ? 1'b1 : 1'b0; ez[2] = 1'b0; ez[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 1'b1, sa[i], (i == 1 && p == 1) ? 16'h0001 : 16'h0000,
              (i % 2 == 1) ? 5'h0F : 5'h1F, (i == 2) ? no255 : ones,
              (i == 1) ? 3'h3 : 3'h7);
        tick();
        if (i >= 1) begin
          check("t2_zv16", zv16, 1'b1);
          check("t2_z16", z16, ez[i-1]);
        end
      end
      drive(1'b1, 1'b0, 16'h0000, 16'h0000, 5'h00, {256{1'b0}}, 3'h0);
      tick();
      check("t2_zv16_last", zv16, 1'b1); check("t2_z16_last", z16, ez[3]);
      tick();
      check("t2_zv16_drop", zv16, 1'b0); check("t2_z16_hold", z16, ez[3]);
      tick(); tick(); tick();
    end

    // Stall with a result in flight; the sample offered during the stall is dropped.
    drive(1'b1, 1'b1, 16'hFFFE, 16'h0000, 5'h1F, ones, 3'h7);
    tick();
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0000, 5'h0F, no255, 3'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_zv16_frozen", zv16, 1'b0); check("t3_z16_frozen", z16, 1'b1);
      check("t3_zv3_held", zv3, 1'b1);     check("t3_z3_held", z3, 1'b1);
    end
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 5'h00, {256{1'b0}}, 3'h0);
    tick();
    check("t3_zv16", zv16, 1'b1); check("t3_z16", z16, 1'b0);
    tick();
    check("t3_zv16_drop", zv16, 1'b0); check("t3_zv3_drop", zv3, 1'b0);
    tick(); tick(); tick();

    // Stall while ZV=1 keeps the result asserted.
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0000, 5'h1F, ones, 3'h7);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 5'h00, {256{1'b0}}, 3'h0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 5'h00, {256{1'b0}}, 3'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_zv16_stall", zv16, 1'b1); check("t4_z16_stall", z16, 1'b1);
    end
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 5'h00, {256{1'b0}}, 3'h0);
    tick();
    check("t4_zv16_drop", zv16, 1'b0);
    tick(); tick(); tick();

    // Asynchronous reset with two samples in flight.
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0000, 5'h0F, ones, 3'h7);
    tick();
    drive(1'b1, 1'b1, 16'hFFFE, 16'h0000, 5'h0F, ones, 3'h7);
    tick();
    #2;
    RST = 1'b1;
    q16.delete(); q5.delete(); q256.delete(); q3.delete();
    #1;
    check("t5_z16", z16, 1'b0); check("t5_zv16", zv16, 1'b0);
    check("t5_z5", z5, 1'b0);   check("t5_zv5", zv5, 1'b0);
    check("t5_z256", z256, 1'b0); check("t5_zv256", zv256, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 5'h00, {256{1'b0}}, 3'h0);
    #2;
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_zv16_quiet", zv16, 1'b0);
      check("t5_zv256_quiet", zv256, 1'b0);
      check("t5_zv3_quiet", zv3, 1'b0);
    end

    // Recovery after reset, then drain.
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0000, 5'h0F, no255, 3'h7);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 5'h00, {256{1'b0}}, 3'h0);
    for (int i = 0; i < 6; i++) tick();
    check("drain_q16", (q16.size() == 0) ? 1'b1 : 1'b0, 1'b1);
    check("drain_q5", (q5.size() == 0) ? 1'b1 : 1'b0, 1'b1);
    check("drain_q256", (q256.size() == 0) ? 1'b1 : 1'b0, 1'b1);
    check("drain_q3", (q3.size() == 0) ? 1'b1 : 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
